bless_nic: RTL and testbench

- Node-side network interface for the bufferless (BLESS) router. It attaches to the router's local port 4.
- Injection side: accepts messages from the local client, queues them, and presents one flit per cycle on port4_ci/port4_di whenever the router asserts port4_ready.
- Ejection side: captures every valid flit the router drives on port4_co/port4_do. The router cannot be back-pressured, so the block buffers these flits and hands them to the client with a valid/ready handshake.

---
 rtl/bless_pkg.sv | 49 ++++
 rtl/nic_fifo.sv | 46 ++++
 rtl/bless_nic.sv | 141 ++++++++++++++
 tb/tb_bless_nic.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bless_pkg.sv
// ------------------------------------------------------------------------
// bless_pkg: shared widths, control-word fields and entry types for bless_nic. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package bless_pkg;

  localparam int CTRL_W       = 22;
  localparam int DATA_W       = 128;
  localparam int NODE_W       = 8;
  localparam int AGE_W        = 5;

  localparam int CTRL_VALID   = 21;
  localparam int CTRL_AGE_HI  = 20;
  localparam int CTRL_AGE_LO  = 16;
  localparam int CTRL_SRC_HI  = 15;
  localparam int CTRL_SRC_LO  = 8;
  localparam int CTRL_DEST_HI = 7;
  localparam int CTRL_DEST_LO = 0;

  localparam int AGE_MAX      = 31;

  typedef struct packed {
    logic [NODE_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } inj_entry_t;

  typedef struct packed {
    logic [NODE_W-1:0] src;
    logic [DATA_W-1:0] data;
  } ej_entry_t;

  function automatic logic [CTRL_W-1:0] make_ctrl(
    input logic [AGE_W-1:0]  age,
    input logic [NODE_W-1:0] src,
    input logic [NODE_W-1:0] dest
  );
    logic [CTRL_W-1:0] c;
    c                            = '0;
    c[CTRL_VALID]                = 1'b1;
    c[CTRL_AGE_HI:CTRL_AGE_LO]   = age;
    c[CTRL_SRC_HI:CTRL_SRC_LO]   = src;
    c[CTRL_DEST_HI:CTRL_DEST_LO] = dest;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nic_fifo.sv
// ------------------------------------------------------------------------
// nic_fifo: power-of-2 FIFO with wrap-bit pointers; caller guards push/pop. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module nic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

endmodule

`default_nettype wire

// File: rtl/bless_nic.sv
// ------------------------------------------------------------------------
// bless_nic: BLESS router local-port NIC (inject/eject FIFOs). Option: BLESS_NIC_AGE_EN. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module bless_nic
  import bless_pkg::*;
#(
  parameter logic [7:0] NODE_ID   = 8'd0,
  parameter int         INJ_DEPTH = 4,
  parameter int         EJ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inj_valid,
  output logic              inj_ready,
  input  logic [7:0]        inj_dest,
  input  logic [DATA_W-1:0] inj_data,
  output logic [CTRL_W-1:0] rtr_ci,
  output logic [DATA_W-1:0] rtr_di,
  input  logic              rtr_ready,
  input  logic [CTRL_W-1:0] rtr_co,
  input  logic [DATA_W-1:0] rtr_do,
  output logic              ej_valid,
  input  logic              ej_ready,
  output logic [7:0]        ej_src,
  output logic [DATA_W-1:0] ej_data,
  output logic              ej_overflow,
  output logic [7:0]        ej_drops
);

  inj_entry_t       w_inj_wr;
  inj_entry_t       w_inj_head;
  logic             w_inj_full;
  logic             w_inj_empty;
  logic             w_inj_push;
  logic             w_inj_pop;
  logic [AGE_W-1:0] w_age;

  assign w_inj_wr   = '{dest: inj_dest, data: inj_data};
  assign w_inj_push = inj_valid && !w_inj_full;
  assign w_inj_pop  = !w_inj_empty && rtr_ready;
  assign inj_ready  = !w_inj_full;

  nic_fifo #(
    .WIDTH ($bits(inj_entry_t)),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_inj_push),
    .i_pop   (w_inj_pop),
    .i_wdata (w_inj_wr),
    .o_head  (w_inj_head),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty)
  );

`ifdef BLESS_NIC_AGE_EN
  logic [AGE_W-1:0] r_age;

  // A non-empty, non-popping head can only mean rtr_ready was low this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_age <= '0;
    end else if (w_inj_empty || w_inj_pop) begin
      r_age <= '0;
    end else if (r_age != AGE_W'(AGE_MAX)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign w_age = r_age;
`else
  assign w_age = '0;
`endif

  always_comb begin
    rtr_ci = '0;
    rtr_di = '0;
    if (w_inj_pop) begin
      rtr_ci = make_ctrl(w_age, NODE_ID, w_inj_head.dest);
      rtr_di = w_inj_head.data;
    end
  end

  ej_entry_t  w_ej_wr;
  ej_entry_t  w_ej_head;
  logic       w_ej_full;
  logic       w_ej_empty;
  logic       w_ej_cap;
  logic       w_ej_pop;
  logic       w_ej_room;
  logic       w_ej_push;
  logic       w_ej_drop;
  logic       r_ej_overflow;
  logic [7:0] r_ej_drops;
  logic       w_unused;

  assign w_ej_wr   = '{src: rtr_co[CTRL_SRC_HI:CTRL_SRC_LO], data: rtr_do};
  assign w_ej_cap  = rtr_co[CTRL_VALID];
  assign w_ej_pop  = !w_ej_empty && ej_ready;
  // Router cannot stall, so a same-cycle pop is the only way to make room when full.
  assign w_ej_room = !w_ej_full || w_ej_pop;
  assign w_ej_push = w_ej_cap && w_ej_room;
  assign w_ej_drop = w_ej_cap && !w_ej_room;
  assign w_unused  = &{1'b0, rtr_co[CTRL_AGE_HI:CTRL_AGE_LO], rtr_co[CTRL_DEST_HI:CTRL_DEST_LO]};

  nic_fifo #(
    .WIDTH ($bits(ej_entry_t)),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_ej_push),
    .i_pop   (w_ej_pop),
    .i_wdata (w_ej_wr),
    .o_head  (w_ej_head),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ej_overflow <= 1'b0;
      r_ej_drops    <= '0;
    end else if (w_ej_drop) begin
      r_ej_overflow <= 1'b1;
      if (r_ej_drops != 8'hFF) r_ej_drops <= r_ej_drops + 8'd1;
    end
  end

  assign ej_valid    = !w_ej_empty;
  assign ej_src      = w_ej_head.src;
  assign ej_data     = w_ej_head.data;
  assign ej_overflow = r_ej_overflow;
  assign ej_drops    = r_ej_drops;

endmodule

`default_nettype wire

// File: tb/tb_bless_nic.sv
// ------------------------------------------------------------------------
// tb_bless_nic: vector table, directed corner sequences and a queue-based reference model. rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_bless_nic;

`ifdef BLESS_NIC_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inj_valid = 1'b0;
  logic         inj_ready;
  logic [7:0]   inj_dest = '0;
  logic [127:0] inj_data = '0;
  logic [21:0]  rtr_ci;
  logic [127:0] rtr_di;
  logic         rtr_ready = 1'b0;
  logic [21:0]  rtr_co = '0;
  logic [127:0] rtr_do = '0;
  logic         ej_valid;
  logic         ej_ready = 1'b0;
  logic [7:0]   ej_src;
  logic [127:0] ej_data;
  logic         ej_overflow;
  logic [7:0]   ej_drops;

  bless_nic #(.NODE_ID(8'h00), .INJ_DEPTH(4), .EJ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_dest(inj_dest), .inj_data(inj_data),
    .rtr_ci(rtr_ci), .rtr_di(rtr_di), .rtr_ready(rtr_ready),
    .rtr_co(rtr_co), .rtr_do(rtr_do),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_src(ej_src), .ej_data(ej_data),
    .ej_overflow(ej_overflow), .ej_drops(ej_drops)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected entries enter the queues as the edge accepts them.
  typedef struct { logic [7:0] tag; logic [127:0] data; } ent_t;
  ent_t       inj_q[$];
  ent_t       ej_q[$];
  logic [4:0] age_m = '0;
  logic       ov_m = 1'b0;
  logic [7:0] drops_m = '0;

  always @(negedge clk) begin
    int   isz, esz;
    logic ipop, epop, eroom;
    if (!rst) begin
      inj_q.delete();
      ej_q.delete();
      age_m   = '0;
      ov_m    = 1'b0;
      drops_m = '0;
      check("rst_inj_ready", inj_ready, 1);
      check("rst_rtr_ci", rtr_ci, 0);
      check("rst_ej_valid", ej_valid, 0);
    end else begin
      isz = inj_q.size();
      esz = ej_q.size();
      check("m_inj_ready", inj_ready, isz < 4);
      if (isz > 0 && rtr_ready) begin
        check("m_rtr_ci", rtr_ci, {1'b1, (AGE_ON ? age_m : 5'd0), 8'h00, inj_q[0].tag});
        check("m_rtr_di", rtr_di, inj_q[0].data);
      end else begin
        check("m_rtr_ci_idle", rtr_ci, 0);
        check("m_rtr_di_idle", rtr_di, 0);
      end
      check("m_ej_valid", ej_valid, esz > 0);
      if (esz > 0) begin
        check("m_ej_src", ej_src, ej_q[0].tag);
        check("m_ej_data", ej_data, ej_q[0].data);
      end
      check("m_ej_overflow", ej_overflow, ov_m);
      check("m_ej_drops", ej_drops, drops_m);

      ipop = (isz > 0) && rtr_ready;
      if (isz == 0 || ipop) age_m = '0;
      else if (age_m != 5'd31) age_m = age_m + 5'd1;
      if (ipop) void'(inj_q.pop_front());
      if (inj_valid && isz < 4) inj_q.push_back('{tag: inj_dest, data: inj_data});

      epop  = (esz > 0) && ej_ready;
      eroom = (esz < 4) || epop;
      if (epop) void'(ej_q.pop_front());
      if (rtr_co[21]) begin
        if (eroom) ej_q.push_back('{tag: rtr_co[15:8], data: rtr_do});
        else begin
          ov_m = 1'b1;
          if (drops_m != 8'hFF) drops_m = drops_m + 8'd1;
        end
      end
    end
  end

  typedef struct {
    logic [7:0]   dest;
    logic [127:0] data;
    logic [21:0]  exp_ci;
  } vec_t;

  vec_t         vec[4];
  logic [127:0] t3_data[4];
  logic [7:0]   t5_src[4];

  initial begin
    vec[0] = '{8'h01, 128'h0123456789abcdef0123456789abcdef, 22'h200001};
    vec[1] = '{8'hFF, 128'hffffffff00000000ffffffff00000000, 22'h2000FF};
    vec[2] = '{8'h5A, 128'h00000000000000000000000000000001, 22'h20005A};
    vec[3] = '{8'h00, 128'hdeadbeefcafef00d1122334455667788, 22'h200000};
    t5_src = '{8'h21, 8'h22, 8'h23, 8'h30};

    // 1: reset values, then single-flit injection vectors
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("reset_inj_ready", inj_ready, 1);
    check("reset_ej_valid", ej_valid, 0);
    check("reset_rtr_di", rtr_di, 0);
    check("reset_drops", ej_drops, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1;
      inj_dest  = vec[i].dest;
      inj_data  = vec[i].data;
      rtr_ready = 1'b1;
      step();
      inj_valid = 1'b0;
      @(negedge clk);
      check("vec_ci", rtr_ci, vec[i].exp_ci);
      check("vec_di", rtr_di, vec[i].data);
      step();
    end
    @(negedge clk);
    check("inj_empty_after", rtr_ci, 0);
    step();

    // 2: age counting and saturation
    rtr_ready = 1'b0;
    inj_valid = 1'b1;
    inj_dest  = 8'h01;
    inj_data  = vec[0].data;
    step();
    inj_valid = 1'b0;
    repeat (5) step();
    rtr_ready = 1'b1;
    @(negedge clk);
    check("age5_ci", rtr_ci, AGE_ON ? 22'h250001 : 22'h200001);
    step();
    rtr_ready = 1'b0;
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    repeat (40) step();
    rtr_ready = 1'b1;
    @(negedge clk);
    check("age_sat_ci", rtr_ci, AGE_ON ? 22'h3F0001 : 22'h200001);
    step();

    // 3: fill injection FIFO, then drain in order back to back
    rtr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t3_data[i] = {4{32'hA000_0000 + 32'(i)}};
      inj_valid  = 1'b1;
      inj_dest   = 8'(32'h10 + i);
      inj_data   = t3_data[i];
      step();
    end
    inj_dest = 8'h99;
    @(negedge clk);
    check("inj_full_ready", inj_ready, 0);
    step();
    inj_valid = 1'b0;
    rtr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", rtr_ci[21], 1);
      check("drain_dest", rtr_ci[7:0], 8'(32'h10 + i));
      check("drain_data", rtr_di, t3_data[i]);
      step();
    end
    @(negedge clk);
    check("drain_done", rtr_ci, 0);
    step();

    // 4: ejection capture and invalid flit ignored
    ej_ready = 1'b1;
    rtr_co   = 22'h200802;
    rtr_do   = 128'h55555555aaaaaaaa55555555aaaaaaaa;
    step();
    rtr_co = '0;
    @(negedge clk);
    check("ej_valid1", ej_valid, 1);
    check("ej_src1", ej_src, 8'h08);
    check("ej_data1", ej_data, 128'h55555555aaaaaaaa55555555aaaaaaaa);
    step();
    rtr_co = 22'h000802;
    step();
    rtr_co = '0;
    @(negedge clk);
    check("ej_ignore", ej_valid, 0);
    step();

    // 5: overflow, then full FIFO with simultaneous pop accepts a flit
    ej_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rtr_co = {1'b1, 5'd0, 8'(32'h20 + i), 8'h00};
      rtr_do = {4{32'hE000_0000 + 32'(i)}};
      step();
    end
    rtr_co = '0;
    @(negedge clk);
    check("ovf_valid", ej_valid, 1);
    check("ovf_flag", ej_overflow, 1);
    check("ovf_drops", ej_drops, 2);
    check("ovf_head", ej_src, 8'h20);
    step();
    ej_ready = 1'b1;
    rtr_co   = {1'b1, 5'd0, 8'h30, 8'h00};
    rtr_do   = 128'h30;
    step();
    rtr_co = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_pop_drops", ej_drops, 2);
      check("full_pop_src", ej_src, t5_src[i]);
      step();
    end
    @(negedge clk);
    check("ej_drained", ej_valid, 0);
    step();

    // 6: asynchronous reset mid-traffic
    rtr_ready = 1'b0;
    ej_ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inj_valid = 1'b1;
      inj_dest  = 8'(32'h40 + i);
      rtr_co    = {1'b1, 5'd0, 8'(32'h50 + i), 8'h00};
      step();
    end
    inj_valid = 1'b0;
    rtr_co    = '0;
    #2;
    rst       = 1'b0;
    rtr_ready = 1'b1;
    #1;
    check("arst_inj_ready", inj_ready, 1);
    check("arst_ej_valid", ej_valid, 0);
    check("arst_rtr_ci", rtr_ci, 0);
    check("arst_rtr_di", rtr_di, 0);
    check("arst_overflow", ej_overflow, 0);
    check("arst_drops", ej_drops, 0);
    step();
    step();
    rst      = 1'b1;
    ej_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ci", rtr_ci, 0);
      check("post_rst_ej", ej_valid, 0);
      step();
    end

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      inj_valid = 1'($urandom_range(0, 1));
      inj_dest  = 8'($urandom);
      inj_data  = {$urandom, $urandom, $urandom, $urandom};
      rtr_ready = ($urandom_range(0, 3) != 0);
      rtr_co    = {1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), 8'($urandom)};
      rtr_do    = {$urandom, $urandom, $urandom, $urandom};
      ej_ready  = ($urandom_range(0, 2) == 0);
      step();
    end
    inj_valid = 1'b0;
    rtr_co    = '0;
    rtr_ready = 1'b1;
    ej_ready  = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("final_inj_idle", rtr_ci, 0);
    check("final_ej_idle", ej_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
